// File: rtl/truth_table_sweeper.sv
`default_nettype none
// ============================================================================
// Module   : truth_table_sweeper
// Brief    : Drives every N_IN-bit input vector in ascending order to a
//            combinational DUT and holds each one for DWELL cycles. It samples
//            the DUT response into a captured truth table and compares that
//            table against a golden one at the end of the sweep.
// Options  : define TT_MISMATCH_DIAG_EN to add the mismatch_cnt and
//            first_fail diagnostic outputs.
// Revision : 1.0 - initial release
// ============================================================================
module truth_table_sweeper #(
    parameter int N_IN  = 4,
    parameter int DWELL = 20
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [2**N_IN-1:0]   expected,
    input  logic                 dut_out,
    output logic [N_IN-1:0]      stim,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2**N_IN-1:0]   tt
`ifdef TT_MISMATCH_DIAG_EN
    ,
    output logic [N_IN:0]        mismatch_cnt,
    output logic [N_IN-1:0]      first_fail
`endif
);

    localparam int              NVEC       = 2**N_IN;
    localparam logic [15:0]     DWELL_LAST = 16'(DWELL - 1);
    localparam logic [N_IN-1:0] LAST_VEC   = '1;
    localparam logic [N_IN-1:0] ONE_VEC    = N_IN'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] dwell_cnt;
    logic        last_dwell;
    logic        accept;

    // The last dwell cycle of a vector is the one where the response is sampled
    assign last_dwell = (dwell_cnt == DWELL_LAST);
    assign accept     = (state == IDLE) && start;

    // Next-state decode and state-derived outputs
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_dwell && (stim == LAST_VEC)) state_nxt = FIN;
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register, vector/dwell counters, truth-table capture and verdict
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            stim      <= '0;
            dwell_cnt <= '0;
            tt        <= '0;
            pass      <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        stim      <= '0;
                        dwell_cnt <= '0;
                        tt        <= '0;
                        pass      <= 1'b0;
                    end
                end
                RUN: begin
                    if (last_dwell) begin
                        tt[stim]  <= dut_out;
                        dwell_cnt <= '0;
                        // Wraps to zero after the last vector, leaving stim=0 in FIN
                        stim      <= stim + ONE_VEC;
                    end else begin
                        dwell_cnt <= dwell_cnt + 16'd1;
                    end
                end
                FIN: begin
                    // tt already holds the final sample written on entry to FIN
                    pass <= (tt == expected);
                    stim <= '0;
                end
                default: begin
                    stim      <= '0;
                    dwell_cnt <= '0;
                end
            endcase
        end
    end

`ifdef TT_MISMATCH_DIAG_EN
    localparam logic [N_IN:0] ONE_CNT = (N_IN+1)'(1);

    logic [NVEC-1:0] diff;
    logic [N_IN:0]   cnt_c;
    logic [N_IN-1:0] first_c;

    // Popcount of mismatching entries and index of the lowest mismatch
    always_comb begin
        diff    = tt ^ expected;
        cnt_c   = '0;
        first_c = '0;
        for (int k = NVEC - 1; k >= 0; k--) begin
            if (diff[k]) begin
                cnt_c   = cnt_c + ONE_CNT;
                first_c = N_IN'(k);
            end
        end
    end

    // Diagnostic results captured alongside pass in FIN
    always_ff @(posedge clk) begin
        if (!rst_n || accept) begin
            mismatch_cnt <= '0;
            first_fail   <= '0;
        end else if (state == FIN) begin
            mismatch_cnt <= cnt_c;
            first_fail   <= first_c;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_truth_table_sweeper.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_truth_table_sweeper
// Brief    : Self-checking bench for truth_table_sweeper: a 4-input AND DUT
//            (N_IN=4, DWELL=20) and an inverter DUT (N_IN=1, DWELL=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_truth_table_sweeper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start;
    logic [15:0] expected;
    logic        dut_out;
    logic        dut_flip;
    logic [3:0]  stim;
    logic        busy, done, pass;
    logic [15:0] tt;

    logic        start1;
    logic [1:0]  expected1;
    logic        dut_out1;
    logic [0:0]  stim1;
    logic        busy1, done1, pass1;
    logic [1:0]  tt1;

`ifdef TT_MISMATCH_DIAG_EN
    logic [4:0]  mismatch_cnt;
    logic [3:0]  first_fail;
    logic [1:0]  mismatch_cnt1;
    logic [0:0]  first_fail1;
`endif

    // Device driven by the sweeper: 4-input AND, optionally inverted
    assign dut_out  = (&stim) ^ dut_flip;
    // Device driven by the single-input sweeper: inverter
    assign dut_out1 = ~stim1[0];

    truth_table_sweeper #(.N_IN(4), .DWELL(20)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .expected(expected),
        .dut_out(dut_out), .stim(stim), .busy(busy), .done(done),
        .pass(pass), .tt(tt)
`ifdef TT_MISMATCH_DIAG_EN
        , .mismatch_cnt(mismatch_cnt), .first_fail(first_fail)
`endif
    );

    truth_table_sweeper #(.N_IN(1), .DWELL(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .expected(expected1),
        .dut_out(dut_out1), .stim(stim1), .busy(busy1), .done(done1),
        .pass(pass1), .tt(tt1)
`ifdef TT_MISMATCH_DIAG_EN
        , .mismatch_cnt(mismatch_cnt1), .first_fail(first_fail1)
`endif
    );

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic [3:0] stim;
    } exp_t;

    exp_t q[$];

    // Expected per-cycle trace of one sweep, starting the cycle after the start edge
    function automatic void push_sweep(input int nvec, input int dwell);
        for (int v = 0; v < nvec; v++)
            for (int d = 0; d < dwell; d++)
                q.push_back('{busy: 1'b1, done: 1'b0, stim: 4'(v)});
        q.push_back('{busy: 1'b0, done: 1'b1, stim: 4'd0});
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; start1 = 1'b1;
        expected = 16'h8000; expected1 = 2'b01; dut_flip = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, stim, pass, tt} !== 23'd0) begin
            errors++;
            $display("FAIL reset_state4 got busy=%b done=%b stim=%0d pass=%b tt=%h want all zero",
                     busy, done, stim, pass, tt);
        end
        checks++;
        if ({busy1, done1, stim1, pass1, tt1} !== 6'd0) begin
            errors++;
            $display("FAIL reset_state1 got busy=%b done=%b stim=%0d pass=%b tt=%b want all zero",
                     busy1, done1, stim1, pass1, tt1);
        end
        // First edge with rst_n high accepts the start that was held during reset
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, stim, busy1, stim1} !== {1'b1, 4'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_release_start got busy=%b stim=%0d busy1=%b stim1=%0d want 1 0 1 0",
                     busy, stim, busy1, stim1);
        end
        start = 1'b0; start1 = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_sweep(input logic [15:0] golden, input bit scramble);
        logic [15:0] model_tt;
        logic [3:0]  kv;
        logic        exp_pass;
        exp_t        e;
        exp_t        obs;
        int          cyc;
        int          n_mis;
        int          first;
        for (int k = 0; k < 16; k++) begin
            kv = 4'(k);
            model_tt[k] = &kv;
        end
        exp_pass = (model_tt == golden);
        n_mis = 0; first = 0;
        for (int k = 15; k >= 0; k--)
            if (model_tt[k] != golden[k]) begin n_mis++; first = k; end
        @(negedge clk);
        expected = scramble ? ~golden : golden;
        start = 1'b1;
        q.delete();
        push_sweep(16, 20);
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (q.size() > 0) begin
            e = q.pop_front();
            obs = {busy, done, stim};
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL sweep_trace cycle %0d got busy=%b done=%b stim=%0d want busy=%b done=%b stim=%0d",
                         cyc, obs.busy, obs.done, obs.stim, e.busy, e.done, e.stim);
            end
            @(negedge clk);
            cyc++;
            // Golden table only matters once the sweep reaches FIN
            if (cyc == 300) expected = golden;
        end
        checks++;
        if ({pass, tt, busy, done} !== {exp_pass, model_tt, 2'b00}) begin
            errors++;
            $display("FAIL sweep_result got pass=%b tt=%h busy=%b done=%b want pass=%b tt=%h busy=0 done=0",
                     pass, tt, busy, done, exp_pass, model_tt);
        end
`ifdef TT_MISMATCH_DIAG_EN
        checks++;
        if ({mismatch_cnt, first_fail} !== {5'(n_mis), 4'(first)}) begin
            errors++;
            $display("FAIL sweep_diag got mismatch_cnt=%0d first_fail=%0d want %0d %0d",
                     mismatch_cnt, first_fail, n_mis, first);
        end
`endif
    endtask

    task automatic test_reset_mid_sweep();
        int n;
        dut_flip = 1'b1;
        @(negedge clk);
        expected = 16'h8000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (stim !== 4'd7 && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 500) begin
            errors++;
            $display("FAIL mid_reset_wait got stim=%0d want 7 within 500 cycles", stim);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        dut_flip = 1'b0;
        checks++;
        if ({busy, done, stim, pass, tt} !== 23'd0) begin
            errors++;
            $display("FAIL mid_reset_state got busy=%b done=%b stim=%0d pass=%b tt=%h want all zero",
                     busy, done, stim, pass, tt);
        end
        test_sweep(16'h8000, 1'b0);
    endtask

    task automatic test_start_held();
        exp_t e;
        exp_t obs;
        int   cyc;
        int   n_done;
        @(negedge clk);
        expected = 16'h8000;
        start = 1'b1;
        q.delete();
        push_sweep(16, 20);
        q.push_back('{busy: 1'b0, done: 1'b0, stim: 4'd0});
        q.push_back('{busy: 1'b1, done: 1'b0, stim: 4'd0});
        @(negedge clk);
        cyc = 1; n_done = 0;
        while (q.size() > 0) begin
            e = q.pop_front();
            obs = {busy, done, stim};
            if (done === 1'b1) n_done++;
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL held_trace cycle %0d got busy=%b done=%b stim=%0d want busy=%b done=%b stim=%0d",
                         cyc, obs.busy, obs.done, obs.stim, e.busy, e.done, e.stim);
            end
            if (cyc == 322) begin
                checks++;
                if (pass !== 1'b1) begin
                    errors++;
                    $display("FAIL held_pass got pass=%b want 1", pass);
                end
            end
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (n_done != 1) begin
            errors++;
            $display("FAIL held_done_count got %0d want 1", n_done);
        end
        start = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_input();
        logic [1:0] model_tt;
        exp_t       e;
        exp_t       obs;
        int         cyc;
        for (int k = 0; k < 2; k++) model_tt[k] = (k == 0);
        @(negedge clk);
        expected1 = 2'b01;
        start1 = 1'b1;
        q.delete();
        push_sweep(2, 2);
        @(negedge clk);
        start1 = 1'b0;
        cyc = 1;
        while (q.size() > 0) begin
            e = q.pop_front();
            obs = {busy1, done1, 3'b000, stim1};
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL single_trace cycle %0d got busy=%b done=%b stim=%0d want busy=%b done=%b stim=%0d",
                         cyc, obs.busy, obs.done, obs.stim, e.busy, e.done, e.stim);
            end
            @(negedge clk);
            cyc++;
        end
        checks++;
        if ({pass1, tt1} !== {(model_tt == expected1), model_tt}) begin
            errors++;
            $display("FAIL single_result got pass=%b tt=%b want pass=1 tt=%b", pass1, tt1, model_tt);
        end
`ifdef TT_MISMATCH_DIAG_EN
        checks++;
        if ({mismatch_cnt1, first_fail1} !== 3'd0) begin
            errors++;
            $display("FAIL single_diag got mismatch_cnt=%0d first_fail=%0d want 0 0",
                     mismatch_cnt1, first_fail1);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_sweep(16'h8000, 1'b1);
        test_sweep(16'h8001, 1'b0);
        test_reset_mid_sweep();
        test_start_held();
        test_single_input();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/truth_table_sweeper.md
TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 SHALL have parameter N_IN, default 4, number of stimulus inputs driven to the DUT (legal 1..8).
REQ-002 SHALL have parameter DWELL, default 20, clock cycles each input vector is held (legal 2..65535).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port start  input  1  request a full sweep; sampled only in IDLE.
REQ-006 SHALL have port expected  input  2**N_IN  golden truth table; bit k is the expected response to vector k.
REQ-007 SHALL have port dut_out  input  1  DUT response under test.
REQ-008 SHALL have port stim  output  N_IN  vector driven to the DUT; bit N_IN-1 is the MSB (the 'a' input).
REQ-009 SHALL have port busy  output  1  high while a sweep is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse at sweep completion.
REQ-011 SHALL have port pass  output  1  registered result of the last completed sweep.
REQ-012 SHALL have port tt  output  2**N_IN  captured truth table; bit k is the dut_out sampled for vector k.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, FIN; IDLE->RUN on start=1, RUN->FIN after the last vector is sampled, FIN->IDLE unconditionally the following cycle.
REQ-014 SHALL, on start accepted at edge T, assert busy=1 with stim=0 and dwell counter=0 from T+1.
REQ-015 SHALL hold each vector for exactly DWELL cycles, increment stim by 1 after the dwell, and drive vectors 0 .. 2**N_IN-1 in ascending order with no repeats or gaps.
REQ-016 SHALL sample dut_out into tt[stim] in the last dwell cycle of each vector (dwell counter = DWELL-1).
REQ-017 SHALL enter FIN after vector 2**N_IN-1 is sampled, so done pulses exactly 1 + (2**N_IN)*DWELL cycles after the start edge.
REQ-018 SHALL in FIN drive done=1, busy=0 and stim=0, and register pass = (tt == expected) using the fully updated tt.
REQ-019 SHALL clear tt to 0 and pass to 0 when a new sweep is accepted; pass and tt SHALL otherwise hold their values until the next accepted start.
REQ-020 SHALL ignore start while in RUN or FIN; it SHALL not restart, extend, or alter the sweep.
REQ-021 SHALL sample expected only in FIN; changes to expected during RUN SHALL have no effect.
REQ-022 SHALL keep stim=0 in IDLE and FIN.

Reset
REQ-023 SHALL, when rst_n=0 at a clock edge, force state=IDLE, stim=0, busy=0, done=0, pass=0, tt=0, and the dwell counter to 0, including mid-sweep.
REQ-024 SHALL accept no start in a cycle where rst_n=0; the first start is accepted at the first edge with rst_n=1.

Configuration
REQ-025 SHALL compile in, when macro TT_MISMATCH_DIAG_EN is defined, output mismatch_cnt (N_IN+1 bits, count of k where tt[k]!=expected[k]) and first_fail (N_IN bits, lowest such k, 0 if none), both registered in FIN, cleared on accepted start and on reset.
REQ-026 SHALL omit mismatch_cnt, first_fail and all related logic when TT_MISMATCH_DIAG_EN is undefined; all other behaviour SHALL be identical.

Verification
REQ-027 SHALL verify N_IN=4, DWELL=20, DUT=AND of four inputs, expected=16'h8000, start at cycle 0 -> stim steps 0..15 every 20 cycles, done at cycle 321, tt=16'h8000, pass=1.
REQ-028 SHALL verify the same setup with expected=16'h8001 -> pass=0; with macro defined, mismatch_cnt=1 and first_fail=0.
REQ-029 SHALL verify rst_n=0 for one cycle while stim=7 -> next cycle busy=0, stim=0, tt=0; a new start then sweeps from vector 0 and passes.
REQ-030 SHALL verify start held high for the whole sweep -> exactly one done at cycle 321, then a second sweep starts from IDLE only after FIN.
REQ-031 SHALL verify N_IN=1, DWELL=2, DUT=inverter, expected=2'b01 -> stim 0,0,1,1, done 5 cycles after the start edge, tt=2'b01, pass=1.
